// File: rtl/key_onehot_capture.sv
// Push-button front end: four keys are synchronized, debounced and
// edge-detected, and each press is captured as a held one-hot code until it is acknowledged.
module key_onehot_capture #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       ack,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  output logic       overrun
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_n;
  logic [3:0]       key_m, key_s;
  logic [3:0]       stable, stable_q;
  logic [3:0]       press, winner;
  logic [3:0]       code_q, code_d;
  logic             valid_d, overrun_d;
  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= '0;
      key_s <= '0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

  // A level is accepted after DB_CYCLES consecutive differing samples; any bounce restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int unsigned i = 0; i < 4; i++) begin
        if (key_s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  always_comb begin
    winner = '0;
    if (press[3])      winner = 4'b1000;
    else if (press[2]) winner = 4'b0100;
    else if (press[1]) winner = 4'b0010;
    else if (press[0]) winner = 4'b0001;
  end

  always_comb begin
    state_n   = state;
    code_d    = code_q;
    valid_d   = valid;
    overrun_d = overrun;
    case (state)
      IDLE: begin
        if (|press) begin
          code_d  = winner;
          valid_d = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          overrun_d = 1'b0;
          if (|press) begin
            code_d = winner;
          end else begin
            code_d  = '0;
            valid_d = 1'b0;
            state_n = IDLE;
          end
        end else if (|press) begin
          overrun_d = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code_q  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      code_q  <= code_d;
      valid   <= valid_d;
      overrun <= overrun_d;
    end
  end

  assign {A, B, C, D} = code_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture: table of single/multi-key presses
// plus hand sequences for bounce, overrun, ack-with-press and async reset.
module tb_key_onehot_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       ack;
  logic       A, B, C, D, valid, overrun;
  logic [3:0] code;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] keys;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs [8];

  key_onehot_capture #(.DB_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .ack(ack),
    .A(A), .B(B), .C(C), .D(D), .valid(valid), .overrun(overrun)
  );

  assign code = {A, B, C, D};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic ok;
    @(posedge clk);
    #1;
    ok = $onehot0(code) && (valid == (|code));
    chk("invariant", {7'b0, ok}, 8'd1);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Keys change just after an edge; capture lands on the 19th edge after that.
  task automatic press_and_check(input string nm, input logic [3:0] keys, input logic [3:0] exp);
    key_in = keys;
    ticks(18);
    chk({nm, "_early_valid"}, {7'b0, valid}, 8'd0);
    tick();
    chk({nm, "_code"}, {4'b0, code}, {4'b0, exp});
    chk({nm, "_valid"}, {7'b0, valid}, 8'd1);
    chk({nm, "_overrun"}, {7'b0, overrun}, 8'd0);
  endtask

  task automatic release_and_ack(input string nm, input logic [3:0] exp);
    key_in = 4'b0000;
    ticks(20);
    chk({nm, "_held"}, {4'b0, code}, {4'b0, exp});
    pulse_ack();
    chk({nm, "_ack_code"}, {4'b0, code}, 8'd0);
    chk({nm, "_ack_valid"}, {7'b0, valid}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b1000, 4'b1000};
    vecs[1] = '{4'b0100, 4'b0100};
    vecs[2] = '{4'b0010, 4'b0010};
    vecs[3] = '{4'b0001, 4'b0001};
    vecs[4] = '{4'b1111, 4'b1000};
    vecs[5] = '{4'b0011, 4'b0010};
    vecs[6] = '{4'b0101, 4'b0100};
    vecs[7] = '{4'b0110, 4'b0100};

    rst_n = 1'b0; key_in = '0; ack = 1'b0;
    #2;
    chk("rst_code", {4'b0, code}, 8'd0);
    chk("rst_valid", {7'b0, valid}, 8'd0);
    chk("rst_overrun", {7'b0, overrun}, 8'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // ack in IDLE is ignored
    pulse_ack();
    chk("idle_ack_valid", {7'b0, valid}, 8'd0);

    for (int i = 0; i < 8; i++) begin
      press_and_check($sformatf("vec%0d", i), vecs[i].keys, vecs[i].exp_code);
      release_and_ack($sformatf("vec%0d", i), vecs[i].exp_code);
    end

    // Bounce on D: never stable long enough, then a clean rise.
    for (int t = 0; t < 12; t++) begin
      key_in[0] = ~key_in[0];
      ticks(5);
      chk("bounce_no_event", {7'b0, valid}, 8'd0);
    end
    press_and_check("bounce_final", 4'b0001, 4'b0001);
    release_and_ack("bounce", 4'b0001);

    // Simultaneous press: B wins, no overrun, no further event while held.
    press_and_check("simul", 4'b0111, 4'b0100);
    pulse_ack();
    chk("simul_ack_valid", {7'b0, valid}, 8'd0);
    ticks(30);
    chk("simul_no_repeat", {7'b0, valid}, 8'd0);
    chk("simul_no_overrun", {7'b0, overrun}, 8'd0);
    key_in = 4'b0000;
    ticks(20);

    // Overrun: C held, A pressed without ack.
    press_and_check("ovr_c", 4'b0010, 4'b0010);
    key_in = 4'b1000;
    ticks(20);
    chk("ovr_code", {4'b0, code}, 8'h02);
    chk("ovr_flag", {7'b0, overrun}, 8'd1);
    chk("ovr_valid", {7'b0, valid}, 8'd1);
    pulse_ack();
    chk("ovr_ack_code", {4'b0, code}, 8'd0);
    chk("ovr_ack_valid", {7'b0, valid}, 8'd0);
    chk("ovr_ack_flag", {7'b0, overrun}, 8'd0);
    key_in = 4'b0000;
    ticks(20);

    // ack coincident with a new A press while holding D.
    press_and_check("ackp_d", 4'b0001, 4'b0001);
    key_in = 4'b1001;
    ticks(18);
    chk("ackp_before", {4'b0, code}, 8'h01);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ackp_code", {4'b0, code}, 8'h08);
    chk("ackp_valid", {7'b0, valid}, 8'd1);
    chk("ackp_overrun", {7'b0, overrun}, 8'd0);
    release_and_ack("ackp", 4'b1000);

    // Async reset mid-debounce: counters must restart from zero.
    key_in = 4'b0100;
    ticks(10);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdb_code", {4'b0, code}, 8'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(18);
    chk("rstdb_early", {7'b0, valid}, 8'd0);
    tick();
    chk("rstdb_code2", {4'b0, code}, 8'h04);
    chk("rstdb_valid", {7'b0, valid}, 8'd1);

    // Async reset in HOLD with overrun set; outputs clear before any edge.
    key_in = 4'b1100;
    ticks(20);
    chk("rsth_overrun_set", {7'b0, overrun}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsth_code", {4'b0, code}, 8'd0);
    chk("rsth_valid", {7'b0, valid}, 8'd0);
    chk("rsth_overrun", {7'b0, overrun}, 8'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(18);
    chk("rsth_early", {7'b0, valid}, 8'd0);
    tick();
    chk("rsth_recapture", {4'b0, code}, 8'h08);
    chk("rsth_valid2", {7'b0, valid}, 8'd1);
    chk("rsth_overrun2", {7'b0, overrun}, 8'd0);
    release_and_ack("rsth", 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
